tabla_ctrl_sequencer: RTL and testbench

- Control and status stage directly downstream of the AXI4-Lite slave register file.
- Consumes the host-written control register and turns a start-bit toggle into a one-cycle `start` pulse.
- Sequences the accelerator through read, process and write phases using done pulses from the datapath.
- Produces the status word and performance counters that feed back into the slave's input registers for host readback.

---
 rtl/tabla_ctrl_sequencer.sv | 139 +++++++++++++
 tb/tb_tabla_ctrl_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tabla_ctrl_sequencer.sv
// Control/status stage behind the AXI4-Lite register file: turns host control-bit toggles into
// a start pulse, steps READ/PROC/WRITE on datapath done pulses, and reports status and cycle counts.
module tabla_ctrl_sequencer #(
  parameter int PERF_CNTR_WIDTH = 32,
  parameter int CTRL_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CTRL_WIDTH-1:0]      ctrl_in,
  input  logic                       rd_done,
  input  logic                       processing_done,
  input  logic                       wr_done,
  output logic                       start,
  output logic                       tx_done,
  output logic [CTRL_WIDTH-1:0]      status_out,
  output logic [PERF_CNTR_WIDTH-1:0] total_cycles,
  output logic [PERF_CNTR_WIDTH-1:0] rd_cycles,
  output logic [PERF_CNTR_WIDTH-1:0] pr_cycles,
  output logic [PERF_CNTR_WIDTH-1:0] wr_cycles
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    PROC  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t          state, next_state;
  logic [1:0]      sampled;
  logic            primed;
  logic            start_tog, clr_tog, idle_clear;
  logic            enter_read, timeout_hit, wd_expired, busy;
  logic [WD_W-1:0] wd_cnt;
  logic            done_flag, start_dropped, timeout_flag;
  logic            unused_ctrl_bits;

  assign unused_ctrl_bits = ^ctrl_in[CTRL_WIDTH-1:2];

  // No toggle can be seen until one post-reset sample has been captured.
  assign start_tog  = primed && (ctrl_in[0] != sampled[0]);
  assign clr_tog    = primed && (ctrl_in[1] != sampled[1]);
  assign idle_clear = clr_tog && (state == IDLE);
  assign busy       = (state == READ) || (state == PROC) || (state == WRITE);
  assign wd_expired = (TIMEOUT_CYCLES > 0) && (wd_cnt == WD_LAST);

  function automatic logic [PERF_CNTR_WIDTH-1:0] sat_inc(input logic [PERF_CNTR_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every output of a combinational block gets a default first, otherwise a path that
  // leaves it unassigned infers a latch.
  always_comb begin
    next_state  = state;
    enter_read  = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      IDLE: if (start_tog) begin
        next_state = READ;
        enter_read = 1'b1;
      end
      READ:  if (rd_done)         next_state = PROC;
             else if (wd_expired) begin next_state = IDLE; timeout_hit = 1'b1; end
      PROC:  if (processing_done) next_state = WRITE;
             else if (wd_expired) begin next_state = IDLE; timeout_hit = 1'b1; end
      WRITE: if (wr_done)         next_state = DONE;
             else if (wd_expired) begin next_state = IDLE; timeout_hit = 1'b1; end
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples the pre-edge
  // values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sampled       <= 2'b00;
      primed        <= 1'b0;
      start         <= 1'b0;
      tx_done       <= 1'b0;
      wd_cnt        <= '0;
      total_cycles  <= '0;
      rd_cycles     <= '0;
      pr_cycles     <= '0;
      wr_cycles     <= '0;
      done_flag     <= 1'b0;
      start_dropped <= 1'b0;
      timeout_flag  <= 1'b0;
    end else begin
      sampled <= ctrl_in[1:0];
      primed  <= 1'b1;
      start   <= enter_read;
      tx_done <= (next_state == DONE);
      wd_cnt  <= (busy && next_state == state) ? wd_cnt + 1'b1 : '0;

      if (enter_read || idle_clear) begin
        total_cycles <= '0;
        rd_cycles    <= '0;
        pr_cycles    <= '0;
        wr_cycles    <= '0;
      end else begin
        if (busy) total_cycles <= sat_inc(total_cycles);
        if (state == READ)  rd_cycles <= sat_inc(rd_cycles);
        if (state == PROC)  pr_cycles <= sat_inc(pr_cycles);
        if (state == WRITE) wr_cycles <= sat_inc(wr_cycles);
      end

      if (enter_read || idle_clear) done_flag <= 1'b0;
      else if (next_state == DONE)  done_flag <= 1'b1;

      if (enter_read || idle_clear) timeout_flag <= 1'b0;
      else if (timeout_hit)         timeout_flag <= 1'b1;

      // A start request outside IDLE is dropped but remembered for the host.
      if (idle_clear)                           start_dropped <= 1'b0;
      else if (start_tog && state != IDLE)      start_dropped <= 1'b1;
    end
  end

  always_comb begin
    status_out      = '0;
    status_out[0]   = busy;
    status_out[3:1] = state;
    status_out[4]   = done_flag;
    status_out[5]   = start_dropped;
    status_out[6]   = timeout_flag;
  end

endmodule

// File: tb/tb_tabla_ctrl_sequencer.sv
// Directed self-checking bench for tabla_ctrl_sequencer: one default instance and one with
// 4-bit counters and a 20-cycle watchdog.
module tb_tabla_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ctrl_in = 32'h1;
  logic        rd_done = 1'b0, processing_done = 1'b0, wr_done = 1'b0;
  logic        start, tx_done;
  logic [31:0] status_out, total_cycles, rd_cycles, pr_cycles, wr_cycles;

  logic [31:0] ctrl2 = 32'h0;
  logic        rd2 = 1'b0, pd2 = 1'b0, wd2 = 1'b0;
  logic        start2, tx2;
  logic [31:0] status2;
  logic [3:0]  tot2, rdc2, prc2, wrc2;

  int checks = 0;
  int errors = 0;
  int n_start = 0, n_tx = 0, n_start2 = 0, n_tx2 = 0;

  tabla_ctrl_sequencer dut (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in),
    .rd_done(rd_done), .processing_done(processing_done), .wr_done(wr_done),
    .start(start), .tx_done(tx_done), .status_out(status_out),
    .total_cycles(total_cycles), .rd_cycles(rd_cycles),
    .pr_cycles(pr_cycles), .wr_cycles(wr_cycles)
  );

  tabla_ctrl_sequencer #(.PERF_CNTR_WIDTH(4), .CTRL_WIDTH(32), .TIMEOUT_CYCLES(20)) dut2 (
    .clk(clk), .reset(reset), .ctrl_in(ctrl2),
    .rd_done(rd2), .processing_done(pd2), .wr_done(wd2),
    .start(start2), .tx_done(tx2), .status_out(status2),
    .total_cycles(tot2), .rd_cycles(rdc2),
    .pr_cycles(prc2), .wr_cycles(wrc2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start)  n_start++;
    if (tx_done) n_tx++;
    if (start2) n_start2++;
    if (tx2)    n_tx2++;
  end

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (status_out !== 32'h0) begin errors++; $display("FAIL reset_status: got %0h expected 0", status_out); end
    checks++; if (total_cycles !== 32'h0) begin errors++; $display("FAIL reset_total: got %0h expected 0", total_cycles); end
    checks++; if (start !== 1'b0 || tx_done !== 1'b0) begin errors++; $display("FAIL reset_pulses: got start=%b tx_done=%b expected 0 0", start, tx_done); end
    checks++; if (status2 !== 32'h0) begin errors++; $display("FAIL reset_status2: got %0h expected 0", status2); end
    reset = 1'b0;
    // ctrl_in[0] stays 1 across the release: no start may follow.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL prime_no_start: cycle %0d got %b expected 0", c, start); end
    end
    checks++; if (status_out !== 32'h0) begin errors++; $display("FAIL prime_status: got %0h expected 0", status_out); end
  endtask

  task automatic run_txn(input string name, input int nr, input int np, input int nw,
                         input bit wr_in_read, input bit clr_in_read, input bit drop_in_proc,
                         input logic [31:0] status_end);
    int s0, t0;
    logic [31:0] got_c [4];
    logic [31:0] exp_c [4];
    s0 = n_start;
    t0 = n_tx;
    ctrl_in[0] = ~ctrl_in[0];
    @(negedge clk);
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL %s start_pulse: got %b expected 1", name, start); end
    for (int c = 1; c <= nr; c++) begin
      if (c == 1 || (c == 3 && (wr_in_read || clr_in_read))) begin
        checks++; if (status_out[3:0] !== 4'h3) begin errors++; $display("FAIL %s in_read c%0d: got %0h expected 3", name, c, status_out[3:0]); end
      end
      if (c == 3 && clr_in_read) begin
        checks++; if (rd_cycles !== 32'd2) begin errors++; $display("FAIL %s busy_clear_rd: got %0d expected 2", name, rd_cycles); end
      end
      if (c == 2 && wr_in_read)  wr_done = 1'b1;
      if (c == 2 && clr_in_read) ctrl_in[1] = ~ctrl_in[1];
      if (c == nr) rd_done = 1'b1;
      @(negedge clk);
      rd_done = 1'b0;
      wr_done = 1'b0;
    end
    for (int c = 1; c <= np; c++) begin
      if (c == 1) begin
        checks++; if (status_out[3:0] !== 4'h5) begin errors++; $display("FAIL %s in_proc: got %0h expected 5", name, status_out[3:0]); end
      end
      if (c == 2 && drop_in_proc) ctrl_in[0] = ~ctrl_in[0];
      if (c == 3 && drop_in_proc) begin
        checks++; if (status_out[5] !== 1'b1) begin errors++; $display("FAIL %s drop_flag: got %b expected 1", name, status_out[5]); end
      end
      if (c == np) processing_done = 1'b1;
      @(negedge clk);
      processing_done = 1'b0;
    end
    for (int c = 1; c <= nw; c++) begin
      if (c == 1) begin
        checks++; if (status_out[3:0] !== 4'h7) begin errors++; $display("FAIL %s in_write: got %0h expected 7", name, status_out[3:0]); end
      end
      if (c == nw) wr_done = 1'b1;
      @(negedge clk);
      wr_done = 1'b0;
    end
    checks++; if (tx_done !== 1'b1 || status_out[4:0] !== 5'h18) begin errors++; $display("FAIL %s done_state: got tx_done=%b status=%0h expected 1 18", name, tx_done, status_out[4:0]); end
    @(negedge clk);
    checks++; if (status_out !== status_end) begin errors++; $display("FAIL %s end_status: got %0h expected %0h", name, status_out, status_end); end
    got_c = '{total_cycles, rd_cycles, pr_cycles, wr_cycles};
    exp_c = '{32'(nr + np + nw), 32'(nr), 32'(np), 32'(nw)};
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_c[i] !== exp_c[i]) begin errors++; $display("FAIL %s counter%0d: got %0d expected %0d", name, i, got_c[i], exp_c[i]); end
    end
    checks++; if (n_start - s0 !== 1 || n_tx - t0 !== 1) begin errors++; $display("FAIL %s pulse_counts: got start=%0d tx=%0d expected 1 1", name, n_start - s0, n_tx - t0); end
  endtask

  task automatic test_basic;         run_txn("basic",   5, 8, 3, 0, 0, 0, 32'h10); endtask
  task automatic test_ignored_done;  run_txn("ignored", 5, 8, 3, 1, 0, 0, 32'h10); endtask
  task automatic test_start_dropped; run_txn("dropped", 5, 8, 3, 0, 0, 1, 32'h30); endtask
  task automatic test_clear_busy;    run_txn("clrbusy", 4, 2, 6, 0, 1, 0, 32'h30); endtask

  task automatic test_soft_clear;
    ctrl_in[1] = ~ctrl_in[1];
    @(negedge clk);
    checks++; if (status_out !== 32'h0) begin errors++; $display("FAIL soft_clear_status: got %0h expected 0", status_out); end
    checks++; if ({total_cycles, rd_cycles, pr_cycles, wr_cycles} !== 128'h0) begin errors++; $display("FAIL soft_clear_counters: got %0h %0h %0h %0h expected 0", total_cycles, rd_cycles, pr_cycles, wr_cycles); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL soft_clear_start: got %b expected 0", start); end
  endtask

  task automatic test_timeout_saturation;
    int s0, t0;
    s0 = n_start2;
    t0 = n_tx2;
    ctrl2[0] = 1'b1;
    @(negedge clk);
    checks++; if (start2 !== 1'b1) begin errors++; $display("FAIL wd_start: got %b expected 1", start2); end
    for (int c = 1; c <= 20; c++) begin
      if (c == 16) begin
        checks++; if (rdc2 !== 4'd15) begin errors++; $display("FAIL sat_reach: got %0d expected 15", rdc2); end
      end
      if (c == 20) begin
        checks++; if (status2 !== 32'h3) begin errors++; $display("FAIL wd_last_read: got %0h expected 3", status2); end
      end
      @(negedge clk);
    end
    checks++; if (status2 !== 32'h40) begin errors++; $display("FAIL wd_status: got %0h expected 40", status2); end
    checks++; if (rdc2 !== 4'd15 || tot2 !== 4'd15 || prc2 !== 4'd0 || wrc2 !== 4'd0) begin errors++; $display("FAIL sat_counters: got %0d %0d %0d %0d expected 15 15 0 0", tot2, rdc2, prc2, wrc2); end
    @(negedge clk);
    checks++; if (rdc2 !== 4'd15 || status2 !== 32'h40) begin errors++; $display("FAIL wd_hold: got rd=%0d status=%0h expected 15 40", rdc2, status2); end
    checks++; if (n_tx2 - t0 !== 0 || n_start2 - s0 !== 1) begin errors++; $display("FAIL wd_pulses: got tx=%0d start=%0d expected 0 1", n_tx2 - t0, n_start2 - s0); end
  endtask

  task automatic test_reset_mid;
    ctrl_in[0] = ~ctrl_in[0];
    repeat (2) @(negedge clk);
    checks++; if (rd_cycles !== 32'd1) begin errors++; $display("FAIL mid_pre_reset: got %0d expected 1", rd_cycles); end
    reset = 1'b1;
    #1;
    checks++; if (status_out !== 32'h0 || rd_cycles !== 32'h0 || total_cycles !== 32'h0) begin errors++; $display("FAIL mid_reset: got status=%0h rd=%0d total=%0d expected 0 0 0", status_out, rd_cycles, total_cycles); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (start !== 1'b0 || status_out !== 32'h0) begin errors++; $display("FAIL mid_after: cycle %0d got start=%b status=%0h expected 0 0", c, start, status_out); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignored_done();
    test_start_dropped();
    test_clear_busy();
    test_soft_clear();
    test_timeout_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
